// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter giving a CPU and a DMA requester exclusive
// LAT-cycle access to a single memory port.
module mem_arbiter #(
    parameter int AW  = 13,
    parameter int DW  = 8,
    parameter int LAT = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic          cpu_gnt,
    output logic          dma_gnt,
    output logic          cpu_done,
    output logic          dma_done,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_read,
    output logic          mem_write,
    input  logic [DW-1:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t        state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic          last_dma_q, last_dma_d;
    logic          own_dma_q, own_dma_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          win_dma;
    // On a tie the requester that did not own the memory last time wins.
    assign win_dma = dma_req & (~cpu_req | ~last_dma_q);
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_dma_d = last_dma_q;
        own_dma_d  = own_dma_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        case (state_q)
            IDLE: if (cpu_req | dma_req) begin
                state_d    = ACCESS;
                cnt_d      = 3'(LAT - 1);
                own_dma_d  = win_dma;
                last_dma_d = win_dma;
                we_d       = win_dma ? dma_we : cpu_we;
                addr_d     = win_dma ? dma_addr : cpu_addr;
                wdata_d    = win_dma ? dma_wdata : cpu_wdata;
            end
            ACCESS: if (cnt_q == 3'd0) begin
                state_d = RESP;
                rdata_d = we_q ? rdata_q : mem_rdata;
            end else begin
                cnt_d = cnt_q - 3'd1;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            last_dma_q <= 1'b1;
            own_dma_q  <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_dma_q <= last_dma_d;
            own_dma_q  <= own_dma_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
        end
    end
    assign cpu_gnt   = (state_q != IDLE) & ~own_dma_q;
    assign dma_gnt   = (state_q != IDLE) & own_dma_q;
    assign cpu_done  = (state_q == RESP) & ~own_dma_q;
    assign dma_done  = (state_q == RESP) & own_dma_q;
    assign rdata     = rdata_q;
    assign mem_read  = (state_q == ACCESS) & ~we_q;
    assign mem_write = (state_q == ACCESS) & we_q;
    assign mem_addr  = (state_q == ACCESS) ? addr_q : '0;
    assign mem_wdata = (state_q == ACCESS) ? wdata_q : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of arbitration, timing and reset behaviour
// on LAT=2, LAT=1 and LAT=8 instances sharing one set of requester inputs.
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0, dma_req = 1'b0, dma_we = 1'b0;
    logic [12:0] cpu_addr = '0, dma_addr = '0;
    logic [7:0]  cpu_wdata = '0, dma_wdata = '0;
    logic        cpu_gnt, dma_gnt, cpu_done, dma_done, mem_read, mem_write;
    logic [7:0]  rdata, mem_wdata, mem_rdata;
    logic [12:0] mem_addr;
    logic        l1_cpu_gnt, l1_dma_gnt, l1_cpu_done, l1_dma_done, l1_mem_read, l1_mem_write;
    logic [7:0]  l1_rdata, l1_mem_wdata, l1_mem_rdata;
    logic [12:0] l1_mem_addr;
    logic        l8_cpu_gnt, l8_dma_gnt, l8_cpu_done, l8_dma_done, l8_mem_read, l8_mem_write;
    logic [7:0]  l8_rdata, l8_mem_wdata, l8_mem_rdata;
    logic [12:0] l8_mem_addr;
    int          vectors = 0;
    int          miscompares = 0;
    logic [5:0]  exp;
    logic [2:0]  exp3;
    always #5 clk = ~clk;
    // Memory returns a fixed function of the address: 0x10 -> 0x5A.
    assign mem_rdata    = mem_addr[7:0] ^ 8'h4A;
    assign l1_mem_rdata = l1_mem_addr[7:0] ^ 8'h4A;
    assign l8_mem_rdata = l8_mem_addr[7:0] ^ 8'h4A;
    mem_arbiter #(.AW(13), .DW(8), .LAT(2)) u_dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .cpu_gnt(cpu_gnt), .dma_gnt(dma_gnt), .cpu_done(cpu_done), .dma_done(dma_done),
        .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata));
    mem_arbiter #(.AW(13), .DW(8), .LAT(1)) u_l1 (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .cpu_gnt(l1_cpu_gnt), .dma_gnt(l1_dma_gnt), .cpu_done(l1_cpu_done), .dma_done(l1_dma_done),
        .rdata(l1_rdata), .mem_addr(l1_mem_addr), .mem_wdata(l1_mem_wdata),
        .mem_read(l1_mem_read), .mem_write(l1_mem_write), .mem_rdata(l1_mem_rdata));
    mem_arbiter #(.AW(13), .DW(8), .LAT(8)) u_l8 (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .cpu_gnt(l8_cpu_gnt), .dma_gnt(l8_dma_gnt), .cpu_done(l8_cpu_done), .dma_done(l8_dma_done),
        .rdata(l8_rdata), .mem_addr(l8_mem_addr), .mem_wdata(l8_mem_wdata),
        .mem_read(l8_mem_read), .mem_write(l8_mem_write), .mem_rdata(l8_mem_rdata));
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic test_reset;
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
        vectors++;
        if ({cpu_gnt, dma_gnt, cpu_done, dma_done, mem_read, mem_write, mem_addr, mem_wdata, rdata} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs got %b want all zero",
                     {cpu_gnt, dma_gnt, cpu_done, dma_done, mem_read, mem_write, mem_addr, mem_wdata, rdata});
        end
        vectors++;
        if ({l1_cpu_gnt, l1_cpu_done, l1_mem_read, l1_rdata, l8_cpu_gnt, l8_cpu_done, l8_mem_read, l8_rdata} !== '0) begin
            miscompares++;
            $display("FAIL reset_lat1_lat8 got l1 gnt=%b rdata=%h l8 gnt=%b rdata=%h want zero",
                     l1_cpu_gnt, l1_rdata, l8_cpu_gnt, l8_rdata);
        end
    endtask
    task automatic test_cpu_read;
        cpu_we = 1'b0;
        cpu_addr = 13'h0010;
        cpu_req = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick;
            if (k == 3) cpu_req = 1'b0;
            exp = {k <= 2, 1'b0, k <= 3, k == 3, 1'b0, 1'b0};
            vectors++;
            if ({mem_read, mem_write, cpu_gnt, cpu_done, dma_gnt, dma_done} !== exp) begin
                miscompares++;
                $display("FAIL cpu_read_ctl k=%0d got %b want %b", k,
                         {mem_read, mem_write, cpu_gnt, cpu_done, dma_gnt, dma_done}, exp);
            end
            vectors++;
            if (mem_addr !== (k <= 2 ? 13'h0010 : 13'h0000)) begin
                miscompares++;
                $display("FAIL cpu_read_addr k=%0d got %h", k, mem_addr);
            end
        end
        vectors++;
        if (rdata !== 8'h5A) begin
            miscompares++;
            $display("FAIL cpu_read_rdata got %h want 5a", rdata);
        end
    endtask
    task automatic test_dma_write;
        dma_we = 1'b1;
        dma_addr = 13'h1FFF;
        dma_wdata = 8'hC3;
        dma_req = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick;
            if (k == 3) dma_req = 1'b0;
            exp = {1'b0, k <= 2, 1'b0, 1'b0, k <= 3, k == 3};
            vectors++;
            if ({mem_read, mem_write, cpu_gnt, cpu_done, dma_gnt, dma_done} !== exp) begin
                miscompares++;
                $display("FAIL dma_write_ctl k=%0d got %b want %b", k,
                         {mem_read, mem_write, cpu_gnt, cpu_done, dma_gnt, dma_done}, exp);
            end
            vectors++;
            if ({mem_addr, mem_wdata} !== (k <= 2 ? {13'h1FFF, 8'hC3} : 21'h0)) begin
                miscompares++;
                $display("FAIL dma_write_port k=%0d got addr=%h wdata=%h", k, mem_addr, mem_wdata);
            end
        end
        vectors++;
        if (rdata !== 8'h5A) begin
            miscompares++;
            $display("FAIL dma_write_rdata got %h want 5a", rdata);
        end
    endtask
    task automatic test_drop;
        int dones;
        dones = 0;
        cpu_we = 1'b0;
        cpu_addr = 13'h0033;
        cpu_req = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick;
            if (k == 1) cpu_req = 1'b0;
            dones += int'(cpu_done);
            exp = {k <= 2, 1'b0, k <= 3, k == 3, 1'b0, 1'b0};
            vectors++;
            if ({mem_read, mem_write, cpu_gnt, cpu_done, dma_gnt, dma_done} !== exp) begin
                miscompares++;
                $display("FAIL drop_ctl k=%0d got %b want %b", k,
                         {mem_read, mem_write, cpu_gnt, cpu_done, dma_gnt, dma_done}, exp);
            end
        end
        vectors++;
        if (dones !== 1 || rdata !== 8'h79) begin
            miscompares++;
            $display("FAIL drop_done got dones=%0d rdata=%h want 1 and 79", dones, rdata);
        end
    endtask
    task automatic test_reset_mid;
        cpu_we = 1'b1;
        cpu_addr = 13'h0100;
        cpu_wdata = 8'h77;
        cpu_req = 1'b1;
        tick;
        cpu_req = 1'b0;
        tick;
        vectors++;
        if ({mem_write, mem_wdata, mem_addr} !== {1'b1, 8'h77, 13'h0100}) begin
            miscompares++;
            $display("FAIL rst_mid_access got we=%b wdata=%h addr=%h want 1 77 0100",
                     mem_write, mem_wdata, mem_addr);
        end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if ({cpu_gnt, dma_gnt, cpu_done, dma_done, mem_read, mem_write, mem_addr, mem_wdata, rdata} !== '0) begin
                miscompares++;
                $display("FAIL rst_mid_idle k=%0d got %b want all zero", k,
                         {cpu_gnt, dma_gnt, cpu_done, dma_done, mem_read, mem_write, mem_addr, mem_wdata, rdata});
            end
            tick;
        end
        cpu_we = 1'b0;
    endtask
    task automatic test_round_robin;
        bit cpu_own;
        int p;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        cpu_we = 1'b0;
        dma_we = 1'b0;
        cpu_addr = 13'h00AB;
        dma_addr = 13'h0155;
        cpu_req = 1'b1;
        dma_req = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick;
            p = (k - 1) % 4;
            cpu_own = ((k - 1) / 4) % 2 == 0;
            exp = {p < 2, 1'b0, p < 3 && cpu_own, p == 2 && cpu_own, p < 3 && !cpu_own, p == 2 && !cpu_own};
            vectors++;
            if ({mem_read, mem_write, cpu_gnt, cpu_done, dma_gnt, dma_done} !== exp) begin
                miscompares++;
                $display("FAIL round_robin_ctl k=%0d got %b want %b", k,
                         {mem_read, mem_write, cpu_gnt, cpu_done, dma_gnt, dma_done}, exp);
            end
            vectors++;
            if (mem_addr !== (p < 2 ? (cpu_own ? 13'h00AB : 13'h0155) : 13'h0000)) begin
                miscompares++;
                $display("FAIL round_robin_addr k=%0d got %h", k, mem_addr);
            end
        end
        cpu_req = 1'b0;
        dma_req = 1'b0;
        vectors++;
        if (rdata !== 8'h1F) begin
            miscompares++;
            $display("FAIL round_robin_rdata got %h want 1f", rdata);
        end
    endtask
    task automatic test_lat;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        cpu_we = 1'b0;
        cpu_addr = 13'h0020;
        cpu_req = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            tick;
            if (k == 1) cpu_req = 1'b0;
            exp3 = {k == 1, k <= 2, k == 2};
            vectors++;
            if ({l1_mem_read, l1_cpu_gnt, l1_cpu_done} !== exp3) begin
                miscompares++;
                $display("FAIL lat1_ctl k=%0d got %b want %b", k, {l1_mem_read, l1_cpu_gnt, l1_cpu_done}, exp3);
            end
            exp3 = {k <= 8, k <= 9, k == 9};
            vectors++;
            if ({l8_mem_read, l8_cpu_gnt, l8_cpu_done} !== exp3) begin
                miscompares++;
                $display("FAIL lat8_ctl k=%0d got %b want %b", k, {l8_mem_read, l8_cpu_gnt, l8_cpu_done}, exp3);
            end
        end
        vectors++;
        if ({l1_rdata, l8_rdata} !== 16'h6A6A) begin
            miscompares++;
            $display("FAIL lat_rdata got l1=%h l8=%h want 6a 6a", l1_rdata, l8_rdata);
        end
    endtask
    initial begin
        #100000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1);
    end
    initial begin
        tick;
        test_reset;
        test_cpu_read;
        test_dma_write;
        test_drop;
        test_reset_mid;
        test_round_robin;
        test_lat;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
